// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants for the P5 pipeline.
package mips_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, HOLD} fetch_state_t;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
   localparam logic [31:0] NOP      = 32'h0000_0000;
endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch port: request/address out, ready/data back.
interface fetch_sequencer_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rdata;

   modport master (output req, addr, input ready, rdata);
   modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_buf.sv
// One-entry skid buffer parking an IM response while IF/ID is stalled.
module fetch_buf (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        valid
);
   always_ff @(posedge clk) begin
      if (reset) begin
         instr <= '0;
         pc    <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         instr <= in_instr;
         pc    <= in_pc;
         valid <= 1'b1;
      end
   end
endmodule

// File: rtl/fetch_sequencer.sv
// PC/IM fetch control: sequential fetch, redirects, stalls, variable-latency IM.
// Optional misaligned-fetch exception enabled by defining FETCH_EXC_EN.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
`ifdef FETCH_EXC_EN
  ,parameter logic [31:0] EXC_VEC  = mips_pkg::EXC_VEC
`endif
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              pc_f,
   output logic [31:0]              npc,
   output logic                     pc_en,
   input  logic                     stall,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   fetch_sequencer_if.master        im,
   output logic                     if_valid,
   output logic [31:0]              if_instr,
   output logic [31:0]              if_pc,
   output logic                     fetch_exc
);
   import mips_pkg::*;

   fetch_state_t state, state_next;
   logic         kill, kill_next;
   logic [31:0]  kill_pc, kill_pc_next;
   logic         buf_load, buf_flush, buf_valid;
   logic [31:0]  buf_instr, buf_pc;

   fetch_buf u_buf (
      .clk      (clk),
      .reset    (reset),
      .load     (buf_load),
      .flush    (buf_flush),
      .in_instr (im.rdata),
      .in_pc    (pc_f),
      .instr    (buf_instr),
      .pc       (buf_pc),
      .valid    (buf_valid)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         kill    <= 1'b0;
         kill_pc <= RESET_PC;
      end else begin
         state   <= state_next;
         kill    <= kill_next;
         kill_pc <= kill_pc_next;
      end
   end

   always_comb begin
      state_next   = state;
      kill_next    = kill;
      kill_pc_next = kill_pc;
      npc          = pc_f + 32'd4;
      pc_en        = 1'b0;
      im.req       = 1'b0;
      im.addr      = pc_f;
      if_valid     = 1'b0;
      if_instr     = NOP;
      if_pc        = pc_f;
      fetch_exc    = 1'b0;
      buf_load     = 1'b0;
      buf_flush    = 1'b0;
      // Outputs stay quiet while reset is high so an in-flight request drops immediately.
      if (reset) begin
         npc = RESET_PC;
      end else begin
         case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
               if (redirect) begin
                  // PC moves now; whatever response is in flight belongs to the old path.
                  im.req       = 1'b1;
                  npc          = redirect_pc;
                  pc_en        = 1'b1;
                  kill_next    = 1'b1;
                  kill_pc_next = redirect_pc;
`ifdef FETCH_EXC_EN
               end else if (pc_f[1:0] != 2'b00) begin
                  fetch_exc = 1'b1;
                  if_valid  = 1'b1;
                  npc       = EXC_VEC;
                  pc_en     = 1'b1;
                  if (im.ready) kill_next = 1'b0;
`endif
               end else begin
                  im.req = 1'b1;
                  if (im.ready) begin
                     if (kill) begin
                        kill_next = 1'b0;
                        npc       = kill_pc;
                        pc_en     = 1'b1;
                     end else if (stall) begin
                        buf_load   = 1'b1;
                        state_next = HOLD;
                     end else begin
                        if_valid = 1'b1;
                        if_instr = im.rdata;
                        pc_en    = 1'b1;
                     end
                  end
               end
            end
            HOLD: begin
               if_instr = buf_instr;
               if_pc    = buf_pc;
               if (redirect) begin
                  npc        = redirect_pc;
                  pc_en      = 1'b1;
                  buf_flush  = 1'b1;
                  state_next = FETCH;
               end else if (!stall) begin
                  if_valid   = buf_valid;
                  pc_en      = 1'b1;
                  buf_flush  = 1'b1;
                  state_next = FETCH;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC register and a programmable-latency IM.
module tb_fetch_sequencer;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_f;
   logic [31:0] npc;
   logic        pc_en;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        fetch_exc;
   int          checks   = 0;
   int          failures = 0;

   fetch_sequencer_if im_bus ();

   fetch_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .pc_f        (pc_f),
      .npc         (npc),
      .pc_en       (pc_en),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .im          (im_bus.master),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .fetch_exc   (fetch_exc)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (reset)      pc_f <= 32'h0000_3000;
      else if (pc_en) pc_f <= npc;
   end

   // Memory word is a tag plus the low address half, so each fetch is recognisable.
   assign im_bus.rdata = {16'hC0DE, im_bus.addr[15:0]};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic st, input logic rd,
                        input logic [31:0] rpc, input logic rdy);
      reset       = r;
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      im_bus.ready = rdy;
      #1;
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   initial begin
      drive(1, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0);
      check("rst_pc_en",     {31'd0, pc_en},     0);
      check("rst_im_req",    {31'd0, im_bus.req}, 0);
      check("rst_if_valid",  {31'd0, if_valid},  0);
      check("rst_fetch_exc", {31'd0, fetch_exc}, 0);
      check("rst_if_instr",  if_instr,           0);
      tick();
      drive(0, 0, 0, 0, 1);
      check("idle_im_req", {31'd0, im_bus.req}, 0);
      check("idle_pc_en",  {31'd0, pc_en},      0);
      tick();

      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 1);
         check("seq_if_valid", {31'd0, if_valid}, 1);
         check("seq_if_pc",    if_pc, 32'h3000 + 32'(4 * i));
         check("seq_pc_en",    {31'd0, pc_en}, 1);
         check("seq_npc",      npc, 32'h3004 + 32'(4 * i));
         tick();
      end

      drive(1, 0, 0, 0, 0);
      check("rst_mid_im_req", {31'd0, im_bus.req}, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      tick();

      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 0);
         check("lat_im_req",   {31'd0, im_bus.req}, 1);
         check("lat_im_addr",  im_bus.addr, 32'h3000);
         check("lat_if_valid", {31'd0, if_valid}, 0);
         check("lat_pc_en",    {31'd0, pc_en}, 0);
         tick();
      end
      drive(0, 0, 0, 0, 1);
      check("lat_done_valid", {31'd0, if_valid}, 1);
      check("lat_done_instr", if_instr, 32'hC0DE_3000);
      check("lat_done_npc",   npc, 32'h3004);
      tick();
      drive(0, 0, 0, 0, 1);
      check("lat_next_pc", if_pc, 32'h3004);
      tick();

      drive(0, 1, 0, 0, 1);
      check("stall_pc_en",    {31'd0, pc_en}, 0);
      check("stall_if_valid", {31'd0, if_valid}, 0);
      tick();
      drive(0, 1, 0, 0, 0);
      check("hold_im_req",   {31'd0, im_bus.req}, 0);
      check("hold_if_valid", {31'd0, if_valid}, 0);
      check("hold_pc_en",    {31'd0, pc_en}, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      check("rel_if_valid", {31'd0, if_valid}, 1);
      check("rel_if_instr", if_instr, 32'hC0DE_3008);
      check("rel_if_pc",    if_pc, 32'h3008);
      check("rel_npc",      npc, 32'h300C);
      check("rel_pc_en",    {31'd0, pc_en}, 1);
      tick();
      drive(0, 0, 0, 0, 1);
      check("after_rel_pc", if_pc, 32'h300C);
      tick();

      drive(0, 0, 1, 32'h3400, 0);
      check("redir_npc",      npc, 32'h3400);
      check("redir_pc_en",    {31'd0, pc_en}, 1);
      check("redir_if_valid", {31'd0, if_valid}, 0);
      tick();
      drive(0, 0, 0, 0, 1);
      check("kill_im_addr",  im_bus.addr, 32'h3400);
      check("kill_if_valid", {31'd0, if_valid}, 0);
      check("kill_npc",      npc, 32'h3400);
      tick();
      drive(0, 0, 0, 0, 1);
      check("tgt_if_valid", {31'd0, if_valid}, 1);
      check("tgt_if_pc",    if_pc, 32'h3400);
      check("tgt_if_instr", if_instr, 32'hC0DE_3400);
      tick();

      drive(0, 1, 0, 0, 1);
      tick();
      drive(0, 1, 1, 32'h3500, 0);
      check("hredir_npc",      npc, 32'h3500);
      check("hredir_pc_en",    {31'd0, pc_en}, 1);
      check("hredir_if_valid", {31'd0, if_valid}, 0);
      tick();
      drive(0, 0, 0, 0, 1);
      check("hredir_if_pc",    if_pc, 32'h3500);
      check("hredir_if_valid2", {31'd0, if_valid}, 1);
      tick();

      drive(0, 0, 1, 32'hFFFF_FFFC, 1);
      check("same_redir_valid", {31'd0, if_valid}, 0);
      check("same_redir_npc",   npc, 32'hFFFF_FFFC);
      tick();
      drive(0, 0, 0, 0, 1);
      check("same_kill_valid", {31'd0, if_valid}, 0);
      tick();
      drive(0, 0, 0, 0, 1);
      check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
      check("wrap_npc",   npc, 32'h0000_0000);
      check("wrap_exc",   {31'd0, fetch_exc}, 0);
      tick();
      drive(0, 0, 0, 0, 1);
      check("wrap_next_pc", if_pc, 32'h0000_0000);
      tick();
      drive(0, 1, 0, 0, 0);
      check("fstall_pc_en",  {31'd0, pc_en}, 0);
      check("fstall_im_req", {31'd0, im_bus.req}, 1);
      tick();

`ifdef FETCH_EXC_EN
      drive(0, 0, 1, 32'h3002, 1);
      tick();
      drive(0, 0, 0, 0, 0);
      check("exc_flag",   {31'd0, fetch_exc}, 1);
      check("exc_valid",  {31'd0, if_valid}, 1);
      check("exc_instr",  if_instr, 32'h0);
      check("exc_npc",    npc, 32'h4180);
      check("exc_im_req", {31'd0, im_bus.req}, 0);
      tick();
      drive(0, 0, 0, 0, 1);
      check("exc_vec_addr", im_bus.addr, 32'h4180);
      tick();
`endif

      drive(1, 0, 0, 0, 1);
      check("rst2_im_req",   {31'd0, im_bus.req}, 0);
      check("rst2_if_valid", {31'd0, if_valid}, 0);
      tick();
      drive(0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 1);
      check("restart_if_pc",    if_pc, 32'h3000);
      check("restart_if_valid", {31'd0, if_valid}, 1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
